act_packer: RTL and testbench
=============================

# act_packer

Streaming requantizer and packer at the output side of a fully-connected layer. It accepts one wide sign-magnitude MAC result per handshake and rescales it to an 8-bit sign-magnitude activation (1 sign bit, 7 magnitude bits). It packs N_OUT activations into the flat `a` vector that the next layer's MAC array consumes, then holds the vector under a valid/ready handshake until the downstream layer takes it.

## Interface
- N_OUT, 30: activations per packed vector (lanes).
- IN_W, 20: width of the incoming sign-magnitude MAC result; the MSB is the sign.
- SHIFT, 8: right-shift applied to the magnitude, with round-half-up; legal range 0..IN_W-2.
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a result.
- in_data  in  IN_W  MAC result: bit IN_W-1 = sign, bits IN_W-2:0 = magnitude.
- flush  in  1  close a partially filled vector early.
- out_valid  out  1  out_vec is complete and stable.
- out_ready  in  1  downstream accepts out_vec.
- out_vec  out  N_OUT*8  packed activations; lane i occupies bits [8*i +: 8], with bit 8*i+7 as the sign.
- out_lanes  out  $clog2(N_OUT+1)  number of lanes written in out_vec; the remaining lanes are zero.

## Operation
- States:
  - FILL: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Accepting a result (FILL, in_valid=1):
  - Requantize in_data and write it into lane idx.
  - Increment idx.
  - If idx was N_OUT-1, go to HOLD with out_lanes=N_OUT.
- Requantize, magnitude path:
  - With SHIFT>0: m = (mag + 2^(SHIFT-1)) >> SHIFT. With SHIFT=0: m = mag.
  - Saturate: if m > 127, m = 127.
- Requantize, sign and zero handling:
  - Result byte = {sign, m[6:0]}.
  - A zero magnitude always gives 8'h00. Negative zero is never emitted.
- Flush:
  - flush in FILL with idx>0: go to HOLD with out_lanes=idx. Unwritten lanes stay 0.
  - flush in FILL with idx=0 and no accept in the same cycle: ignored.
  - flush together with an accept: the sample is written first, then the block goes to HOLD with out_lanes=idx+1.
  - flush in HOLD: ignored.
- Leaving HOLD: on out_valid & out_ready, go to FILL, set idx=0, clear out_vec to 0 and set out_lanes=0.
- Arithmetic is unsigned on the magnitude. The rounding add is IN_W bits wide, so it cannot overflow.

## Timing
- Reset (rst_n=0 at a clock edge):
  - State FILL, idx=0, out_vec=0, out_lanes=0.
  - out_valid=0, in_ready=1 from the first edge after reset.
- Reset mid-vector discards all partial lanes. Reset during HOLD drops the pending vector; no handshake is generated.
- Latency: out_valid rises on the edge that accepts the last lane (or the flush). It is visible in the cycle after that accept.
- in_ready and out_valid are decoded directly from the registered state; they have no combinational path from in_valid or out_ready.
- Throughput: one result per cycle while filling. There is one dead accept cycle per vector: in_ready is low during the cycle in which out_valid & out_ready fire.
- out_vec and out_lanes are stable for the whole time out_valid=1.

## Configuration
- RELU_EN defined: any result with sign=1 becomes 8'h00, so every output lane is non-negative.
- RELU_EN undefined: the sign is passed through per the requantize rule.

## Structure
- Shared package fnn_pkg holds:
  - ACT_W=8, MAG_W=7, ACT_MAX=7'd127.
  - The sign-magnitude activation typedef (struct with sign and mag fields).
  - The state enum {FILL, HOLD}.
- Sub-module sm_requant: combinational; parameters IN_W and SHIFT; maps in_data to an 8-bit activation. It contains the round, saturate, negative-zero and RELU_EN logic.
- act_packer itself owns the FSM, the lane index and the lane registers.

## Test plan
All scenarios use N_OUT=4, SHIFT=8, IN_W=20 unless stated.
- Rounding: mag 127 -> 0x00; mag 128 -> 0x01; mag 384 -> 0x02; negative mag 1000 -> 0x84.
- Saturation and zero:
  - mag 40000 -> 0x7F; negative mag 40000 -> 0xFF.
  - Negative mag 0 -> 0x00.
  - With RELU_EN, negative mag 1000 -> 0x00.
- Full vector: 4 back-to-back accepts (mags 256, 512, 768, 1024, all positive) -> out_vec=32'h04030201, out_lanes=4, out_valid asserted the cycle after the 4th accept.
- Backpressure: out_ready held low for 10 cycles in HOLD -> in_ready=0 and out_vec stable throughout; out_ready=1 -> back to FILL, out_vec=0.
- Flush:
  - 2 accepts then flush -> out_lanes=2, upper 16 bits of out_vec zero.
  - flush with idx=0 -> no out_valid.
  - flush together with the 3rd accept -> out_lanes=3.
- Reset: rst_n low after 3 accepts -> out_valid=0, in_ready=1; the next 4 accepts produce a fresh vector containing no stale lanes.

Source files
------------

// File: rtl/fnn_pkg.sv
// Shared types and constants for the fully-connected layer datapath.
package fnn_pkg;

  localparam int unsigned ACT_W = 8;
  localparam int unsigned MAG_W = 7;
  localparam logic [MAG_W-1:0] ACT_MAX = 7'd127;

  // Sign-magnitude activation: bit 7 sign, bits 6:0 magnitude.
  typedef struct packed {
    logic             sign;
    logic [MAG_W-1:0] mag;
  } act_t;

  typedef enum logic {
    FILL,
    HOLD
  } state_e;

endpackage

// File: rtl/sm_requant.sv
// Combinational requantizer: wide sign-magnitude MAC result -> 8-bit sign-magnitude activation.
// Round-half-up right shift, saturate to 127, never emit negative zero.
// Optional macro RELU_EN: negative inputs map to 8'h00.
module sm_requant
  import fnn_pkg::*;
#(
  parameter int unsigned IN_W  = 20,
  parameter int unsigned SHIFT = 8
) (
  input  logic [IN_W-1:0] in_data_i,
  output act_t            act_o
);

  // Half of one output LSB; zero when no shift is applied.
  localparam logic [IN_W-1:0] Rnd =
      (SHIFT == 0) ? '0 : (IN_W'(1) << ((SHIFT == 0) ? 0 : SHIFT - 1));

  logic             sign;
  logic [IN_W-1:0]  mag_ext;
  logic [IN_W-1:0]  sum;
  logic [IN_W-1:0]  shifted;
  logic [MAG_W-1:0] mag_sat;

  // Magnitude is zero-extended by one bit, so the rounding add cannot overflow.
  assign sign    = in_data_i[IN_W-1];
  assign mag_ext = {1'b0, in_data_i[IN_W-2:0]};
  assign sum     = mag_ext + Rnd;
  assign shifted = sum >> SHIFT;

  // Saturate, then suppress negative zero (and negatives entirely under RELU_EN).
  always_comb begin
    act_o   = '0;
    mag_sat = (shifted > IN_W'(ACT_MAX)) ? ACT_MAX : shifted[MAG_W-1:0];
    if (mag_sat != '0) begin
      act_o.sign = sign;
      act_o.mag  = mag_sat;
    end
`ifdef RELU_EN
    if (sign) begin
      act_o = '0;
    end
`endif
  end

endmodule

// File: rtl/act_packer.sv
// Streaming requantizer/packer: collects N_OUT requantized activations into a flat vector and
// holds it under valid/ready until the next layer takes it. Optional macro RELU_EN (see
// sm_requant) clamps negative activations to zero.
module act_packer
  import fnn_pkg::*;
#(
  parameter int unsigned N_OUT = 30,
  parameter int unsigned IN_W  = 20,
  parameter int unsigned SHIFT = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [IN_W-1:0]              in_data,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N_OUT*ACT_W-1:0]       out_vec,
  output logic [$clog2(N_OUT+1)-1:0]   out_lanes
);

  localparam int unsigned LW = $clog2(N_OUT + 1);

  state_e                 state_q, state_d;
  logic [LW-1:0]          idx_q, idx_d;
  logic [LW-1:0]          lanes_q, lanes_d;
  logic [N_OUT*ACT_W-1:0] vec_q, vec_d;
  act_t                   act;
  logic                   accept;

  sm_requant #(
    .IN_W  (IN_W),
    .SHIFT (SHIFT)
  ) u_requant (
    .in_data_i (in_data),
    .act_o     (act)
  );

  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == HOLD);
  assign out_vec   = vec_q;
  assign out_lanes = lanes_q;
  assign accept    = in_ready && in_valid;

  // State, lane index and lane registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FILL;
      idx_q   <= '0;
      lanes_q <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lanes_q <= lanes_d;
      vec_q   <= vec_d;
    end
  end

  // Next-state: write lanes while filling, close on last lane or flush, clear on handoff.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lanes_d = lanes_q;
    vec_d   = vec_q;
    unique case (state_q)
      FILL: begin
        if (accept) begin
          for (int i = 0; i < int'(N_OUT); i++) begin
            if (LW'(i) == idx_q) begin
              vec_d[ACT_W*i +: ACT_W] = act;
            end
          end
          idx_d = idx_q + 1'b1;
          if (idx_q == LW'(N_OUT - 1) || flush) begin
            state_d = HOLD;
            lanes_d = idx_q + 1'b1;
          end
        end else if (flush && idx_q != '0) begin
          state_d = HOLD;
          lanes_d = idx_q;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = FILL;
          idx_d   = '0;
          lanes_d = '0;
          vec_d   = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

endmodule

// File: tb/tb_act_packer.sv
// Directed self-checking bench for act_packer with N_OUT=4, IN_W=20, SHIFT=8.
module tb_act_packer;

  localparam int unsigned N_OUT = 4;
  localparam int unsigned IN_W  = 20;
  localparam int unsigned SHIFT = 8;

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [IN_W-1:0]     in_data;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic [N_OUT*8-1:0]  out_vec;
  logic [2:0]          out_lanes;

  int n_vec;
  int n_err;

  act_packer #(
    .N_OUT (N_OUT),
    .IN_W  (IN_W),
    .SHIFT (SHIFT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .out_lanes (out_lanes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one sample at the negedge; return 1ns after the capturing posedge.
  task automatic send(input logic sgn, input int unsigned mag, input logic fl);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = {sgn, mag[IN_W-2:0]};
    flush    = fl;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_out_valid got %b exp 0", out_valid);
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_in_ready got %b exp 1", in_ready);
    end
    n_vec++;
    if (out_vec !== 32'h0) begin
      n_err++; $display("FAIL reset_out_vec got %h exp 0", out_vec);
    end
    n_vec++;
    if (out_lanes !== 3'd0) begin
      n_err++; $display("FAIL reset_out_lanes got %0d exp 0", out_lanes);
    end
  endtask

  // Each sample is sent alone with flush, then read back from lane 0.
  task automatic test_requant();
    logic        sg  [9];
    int unsigned mg  [9];
    logic [7:0]  ex  [9];
    sg = '{0, 0, 0, 1, 0, 1, 1, 1, 0};
    mg = '{127, 128, 384, 1000, 40000, 40000, 0, 127, 524287};
`ifdef RELU_EN
    ex = '{8'h00, 8'h01, 8'h02, 8'h00, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h7F};
`else
    ex = '{8'h00, 8'h01, 8'h02, 8'h84, 8'h7F, 8'hFF, 8'h00, 8'h00, 8'h7F};
`endif
    for (int k = 0; k < 9; k++) begin
      send(sg[k], mg[k], 1'b1);
      n_vec++;
      if (out_valid !== 1'b1 || out_lanes !== 3'd1 || out_vec !== {24'h0, ex[k]}) begin
        n_err++;
        $display("FAIL requant[%0d] got valid=%b lanes=%0d vec=%h exp valid=1 lanes=1 vec=%h",
                 k, out_valid, out_lanes, out_vec, {24'h0, ex[k]});
      end
      drain();
    end
  endtask

  task automatic test_full_vector();
    send(0, 256, 0);
    send(0, 512, 0);
    send(0, 768, 0);
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL full_early got valid=%b ready=%b exp 0/1", out_valid, in_ready);
    end
    send(0, 1024, 0);
    n_vec++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL full_valid got valid=%b ready=%b exp 1/0", out_valid, in_ready);
    end
    n_vec++;
    if (out_vec !== 32'h04030201 || out_lanes !== 3'd4) begin
      n_err++;
      $display("FAIL full_vec got %h lanes=%0d exp 04030201 lanes=4", out_vec, out_lanes);
    end
  endtask

  // Continues from the HOLD left by test_full_vector; pushes and flushes are offered meanwhile.
  task automatic test_backpressure();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 20'd2048;
      flush    = (c == 5);
      @(posedge clk);
      #1;
      n_vec++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_vec !== 32'h04030201 ||
          out_lanes !== 3'd4) begin
        n_err++;
        $display("FAIL hold[%0d] got ready=%b valid=%b vec=%h lanes=%0d exp 0/1/04030201/4",
                 c, in_ready, out_valid, out_vec, out_lanes);
      end
    end
    // Handshake cycle with in_valid still high: that sample must not be taken.
    @(negedge clk);
    flush     = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_vec !== 32'h0 || out_lanes !== 3'd0) begin
      n_err++;
      $display("FAIL release got valid=%b ready=%b vec=%h lanes=%0d exp 0/1/0/0",
               out_valid, in_ready, out_vec, out_lanes);
    end
    send(0, 768, 1);
    n_vec++;
    if (out_vec !== 32'h00000003 || out_lanes !== 3'd1) begin
      n_err++;
      $display("FAIL dead_cycle got vec=%h lanes=%0d exp 00000003 lanes=1", out_vec, out_lanes);
    end
    drain();
  endtask

  task automatic test_flush();
    send(0, 256, 0);
    send(0, 512, 0);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1 || out_lanes !== 3'd2 || out_vec !== 32'h00000201) begin
      n_err++;
      $display("FAIL flush2 got valid=%b lanes=%0d vec=%h exp 1/2/00000201",
               out_valid, out_lanes, out_vec);
    end
    drain();
    // Flush with nothing collected is ignored.
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    flush = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL flush_empty got valid=%b ready=%b exp 0/1", out_valid, in_ready);
    end
    send(0, 256, 0);
    send(0, 512, 0);
    send(1, 768, 1);
    n_vec++;
`ifdef RELU_EN
    if (out_valid !== 1'b1 || out_lanes !== 3'd3 || out_vec !== 32'h00000201) begin
      n_err++;
      $display("FAIL flush_accept got valid=%b lanes=%0d vec=%h exp 1/3/00000201",
               out_valid, out_lanes, out_vec);
    end
`else
    if (out_valid !== 1'b1 || out_lanes !== 3'd3 || out_vec !== 32'h00830201) begin
      n_err++;
      $display("FAIL flush_accept got valid=%b lanes=%0d vec=%h exp 1/3/00830201",
               out_valid, out_lanes, out_vec);
    end
`endif
    drain();
  endtask

  task automatic test_reset_mid();
    send(0, 1024, 0);
    send(0, 1024, 0);
    send(0, 1024, 0);
    do_reset();
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_vec !== 32'h0 || out_lanes !== 3'd0) begin
      n_err++;
      $display("FAIL reset_mid got valid=%b ready=%b vec=%h lanes=%0d exp 0/1/0/0",
               out_valid, in_ready, out_vec, out_lanes);
    end
    send(0, 256, 0);
    send(0, 512, 0);
    send(0, 768, 0);
    send(0, 1024, 0);
    n_vec++;
    if (out_valid !== 1'b1 || out_vec !== 32'h04030201 || out_lanes !== 3'd4) begin
      n_err++;
      $display("FAIL fresh_vec got valid=%b vec=%h lanes=%0d exp 1/04030201/4",
               out_valid, out_vec, out_lanes);
    end
    // Reset while holding drops the vector.
    do_reset();
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_vec !== 32'h0) begin
      n_err++;
      $display("FAIL reset_hold got valid=%b ready=%b vec=%h exp 0/1/0",
               out_valid, in_ready, out_vec);
    end
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_requant();
    test_full_vector();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
